// File: rtl/aes_sched_pkg.sv
// ---------------------------------------------------------------------------
// aes_sched_pkg
// Shared types and constants for the AES core scheduler.
//   sched_state_e : scheduler FSM states (IDLE, ISSUE, BUSY, RESP)
//   AES_BLOCK_W   : width of one AES data block
//   MODE_ENC/DEC  : encoding of the per-job mode bit
// ---------------------------------------------------------------------------
package aes_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

    localparam int   AES_BLOCK_W = 128;
    localparam logic MODE_ENC    = 1'b0;
    localparam logic MODE_DEC    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// index ptr+1, searching upwards with wrap-around. The pointer itself lives
// in the parent so it can be updated only on an accepted request.
//
// Ports:
//   req_valid   in  NUM_REQ : request lines
//   ptr         in  IDX_W   : index of the last winner
//   grant       out NUM_REQ : one-hot grant (zero when nothing requests)
//   grant_idx   out IDX_W   : encoded grant index
//   grant_valid out 1       : some request was granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Candidate gi is the requester at distance gi+1 from ptr (wrapped).
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        localparam int OFF = gi + 1;
        logic [IDX_W:0] sum;
        // ptr <= NUM_REQ-1 and OFF <= NUM_REQ, so one subtraction wraps it.
        assign sum = {1'b0, ptr} + (IDX_W+1)'(OFF);
        assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                            : sum[IDX_W-1:0];
        assign cand_hit[gi] = req_valid[cand_idx[gi]];
    end

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx   = cand_idx[k];
                grant_valid = 1'b1;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// ---------------------------------------------------------------------------
// aes_core_scheduler
// Shares one AES round core between NUM_REQ requesters. A round-robin
// arbiter picks a job in IDLE, the job is launched with a one-cycle
// core_start (ISSUE), the scheduler waits for core_done (BUSY) and then
// presents the result with the owner's ID until it is accepted (RESP).
// One job is in flight at a time.
//
// Optional feature: define AES_SCHED_TIMEOUT_EN to build a BUSY watchdog.
// After TIMEOUT_CYCLES BUSY cycles without core_done the job is aborted and
// answered with rsp_err=1, rsp_data=0. Without the macro rsp_err is 0 and
// BUSY waits indefinitely.
//
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid/ready/mode    : per-requester handshake and mode (1 = decrypt)
//   req_data                : packed blocks, requester i at [i*128 +: 128]
//   core_start              : one-cycle launch pulse
//   core_mode, core_data_in : job presented to the core (stable ISSUE..BUSY)
//   core_done, core_data_out: completion pulse and result from the core
//   rsp_valid/ready         : response handshake
//   rsp_data, rsp_id, rsp_err : result, owning requester, watchdog abort
//   busy                    : high whenever not IDLE
// ---------------------------------------------------------------------------
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_mode,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
    output logic                           core_start,
    output logic                           core_mode,
    output logic [AES_BLOCK_W-1:0]         core_data_in,
    input  logic                           core_done,
    input  logic [AES_BLOCK_W-1:0]         core_data_out,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [AES_BLOCK_W-1:0]         rsp_data,
    output logic [ID_W-1:0]                rsp_id,
    output logic                           rsp_err,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   job_mode_q, job_mode_d;
    logic [AES_BLOCK_W-1:0] job_data_q, job_data_d;
    logic [IDX_W-1:0]       job_id_q, job_id_d;
    logic [AES_BLOCK_W-1:0] rsp_data_q, rsp_data_d;
    logic                   tmo_hit;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_valid   (req_valid),
        .ptr         (ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             rsp_err_q, rsp_err_d;

    // tmo_cnt_q holds the number of BUSY cycles already spent, so the limit
    // is reached in the BUSY cycle where it equals TIMEOUT_CYCLES-1.
    assign tmo_hit = (state_q == S_BUSY) &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        rsp_err_d = rsp_err_q;
        if (state_q == S_ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == S_BUSY) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            // core_done wins over a watchdog hit in the same cycle
            if (core_done) begin
                rsp_err_d = 1'b0;
            end else if (tmo_hit) begin
                rsp_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    // The limit only matters with the watchdog built.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
    assign tmo_hit        = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        job_mode_d = job_mode_q;
        job_data_d = job_data_q;
        job_id_d   = job_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                // The winner's valid is high by construction, so a grant in
                // IDLE is a completed handshake.
                if (grant_valid) begin
                    job_mode_d = req_mode[grant_idx];
                    job_data_d = req_data[int'(grant_idx)*AES_BLOCK_W +: AES_BLOCK_W];
                    job_id_d   = grant_idx;
                    ptr_d      = grant_idx;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (core_done) begin
                    rsp_data_d = core_data_out;
                    state_d    = S_RESP;
                end else if (tmo_hit) begin
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            job_mode_q <= MODE_ENC;
            job_data_q <= '0;
            job_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            job_mode_q <= job_mode_d;
            job_data_q <= job_data_d;
            job_id_q   <= job_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // req_ready is also gated by reset_n so it reads 0 while reset is held.
    assign req_ready    = (state_q == S_IDLE && reset_n) ? grant : '0;
    assign core_start   = (state_q == S_ISSUE);
    assign core_mode    = job_mode_q;
    assign core_data_in = job_data_q;
    assign rsp_valid    = (state_q == S_RESP);
    assign rsp_data     = rsp_data_q;
    assign rsp_id       = ID_W'(job_id_q);
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_core_scheduler.sv
module tb_aes_core_scheduler;
    import aes_sched_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int TMO     = 64;
    localparam int BW      = AES_BLOCK_W;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_mode = '0;
    logic [NUM_REQ*BW-1:0] req_data = '0;
    logic                  core_start, core_mode;
    logic [BW-1:0]         core_data_in;
    logic                  core_done = 1'b0;
    logic [BW-1:0]         core_data_out = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [BW-1:0]         rsp_data;
    logic [ID_W-1:0]       rsp_id;
    logic                  rsp_err, busy;

    always #5 clk = ~clk;

    aes_core_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_data(req_data),
        .core_start(core_start), .core_mode(core_mode),
        .core_data_in(core_data_in), .core_done(core_done),
        .core_data_out(core_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // requester side
    logic [NUM_REQ-1:0] pend = '0;
    logic [NUM_REQ-1:0] hs_mask = '0;
    logic [NUM_REQ-1:0] p_mode = '0;
    logic [BW-1:0]      p_data [NUM_REQ];
    bit rnd_req = 0, rnd_rdy = 0, rdy_val = 1, hold_req = 0, spur_en = 0, core_mute = 0;
    int lat_fix = 0;

    // core stand-in
    int            core_cnt = -1;
    logic [BW-1:0] core_res = '0;

    // job-level reference model
    int            m_ptr = NUM_REQ - 1;
    bit            m_act = 0, m_resp = 0;
    int            m_age = 0, m_id = 0;
    logic          m_mode = 1'b0, m_err = 1'b0;
    logic [BW-1:0] m_data = '0, m_res = '0;

    int            grant_log[$];
    int            acc_cyc = -1, first_start = -1, first_rsp = -1, first_rsp_id = -1;
    logic [BW-1:0] first_rsp_data = '0;
    logic          first_rsp_err = 1'b0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core transform: encrypt swaps the 64-bit halves, decrypt inverts.
    function automatic logic [BW-1:0] core_fn(input logic [BW-1:0] d, input logic m);
        return (m == MODE_DEC) ? ~d : {d[63:0], d[127:64]};
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic void clear_marks();
        acc_cyc = -1; first_start = -1; first_rsp = -1;
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare 1 time unit
    // later, then advance the model to what the next rising edge must do.
    task automatic step();
        logic [NUM_REQ-1:0] exp_ready;
        int win;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                p_data[i] = rand128();
                p_mode[i] = 1'($urandom_range(0, 1));
                if (!hold_req) pend[i] = 1'b0;
            end else if (rnd_req) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]   = 1'b1;
                    p_data[i] = rand128();
                    p_mode[i] = 1'($urandom_range(0, 1));
                end else if (pend[i] && $urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
        end
        hs_mask   = '0;
        req_valid = pend;
        req_mode  = p_mode;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*BW +: BW] = p_data[i];
        rsp_ready = rnd_rdy ? ($urandom_range(0, 2) != 0) : rdy_val;
        core_done     = 1'b0;
        core_data_out = rand128();
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done     = 1'b1;
                core_data_out = core_res;
                core_cnt      = -1;
            end
        end else if (spur_en && (!m_act || m_age == 1 || m_resp) && $urandom_range(0, 3) == 0) begin
            core_done = 1'b1;
        end
        #1;
        exp_ready = '0;
        win = -1;
        if (!m_act) begin
            win = rr_pick(m_ptr, req_valid);
            if (win >= 0) exp_ready[win] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_act);
        chk("core_start", core_start, m_act && m_age == 1);
        chk("rsp_valid", rsp_valid, m_act && m_resp);
        if (m_act && !m_resp) begin
            chk("core_mode", core_mode, m_mode);
            chk("core_data_in", core_data_in, m_data);
        end
        if (m_act && m_resp) begin
            chk("rsp_data", rsp_data, m_res);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_err", rsp_err, m_err);
        end
        if (core_start) begin
            if (first_start < 0) first_start = cyc;
            if (!core_mute) begin
                core_cnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 12);
                core_res = core_fn(core_data_in, core_mode);
            end
        end
        if (rsp_valid && first_rsp < 0) begin
            first_rsp      = cyc;
            first_rsp_data = rsp_data;
            first_rsp_id   = int'(rsp_id);
            first_rsp_err  = rsp_err;
        end
        hs_mask = req_ready & req_valid;
        if (m_act) begin
            if (m_resp) begin
                if (rsp_ready) begin
                    $display("cycle %0d: response id=%0d err=%0b data=%h", cyc, m_id, m_err, m_res);
                    m_act  = 0;
                    m_resp = 0;
                end
            end else if (m_age >= 2) begin
                if (core_done) begin
                    m_resp = 1; m_err = 1'b0; m_res = core_fn(m_data, m_mode);
                end
`ifdef AES_SCHED_TIMEOUT_EN
                else if (m_age - 1 >= TMO) begin
                    m_resp = 1; m_err = 1'b1; m_res = '0;
                end
`endif
            end
            m_age++;
        end else if (win >= 0) begin
            m_act  = 1; m_resp = 0; m_age = 1;
            m_id   = win;
            m_mode = req_mode[win];
            m_data = req_data[win*BW +: BW];
            m_ptr  = win;
            grant_log.push_back(win);
            if (acc_cyc < 0) acc_cyc = cyc;
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = '0;
        core_done = 1'b0;
        rsp_ready = 1'b0;
        #1;
        if (check) begin
            chk("rst_req_ready", req_ready, '0);
            chk("rst_core_start", core_start, 1'b0);
            chk("rst_core_mode", core_mode, 1'b0);
            chk("rst_core_data_in", core_data_in, '0);
            chk("rst_rsp_valid", rsp_valid, 1'b0);
            chk("rst_rsp_data", rsp_data, '0);
            chk("rst_rsp_id", rsp_id, '0);
            chk("rst_rsp_err", rsp_err, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        m_act = 0; m_resp = 0; m_ptr = NUM_REQ - 1; m_res = '0;
        core_cnt = -1;
        hs_mask  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_until_rsp(input int budget, input string name);
        int n = 0;
        while (first_rsp < 0 && n < budget) begin
            step();
            n++;
        end
        chk(name, first_rsp >= 0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) p_data[i] = '0;
        repeat (2) @(negedge clk);
        do_reset(1);

        // single encrypt, fixed latency 11
        lat_fix = 11; rdy_val = 1;
        p_data[0] = 128'h00112233445566778899aabbccddeeff;
        p_mode[0] = MODE_ENC;
        pend = 3'b001;
        clear_marks();
        run_until_rsp(30, "t1_rsp_seen");
        chk("t1_start_cycle", first_start - acc_cyc, 1);
        chk("t1_rsp_cycle", first_rsp - acc_cyc, 13);
        chk("t1_rsp_id", first_rsp_id, 0);
        chk("t1_rsp_err", first_rsp_err, 1'b0);
        chk("t1_rsp_data", first_rsp_data, 128'h8899aabbccddeeff0011223344556677);
        repeat (3) step();

        // round-robin with two requesters held valid
        do_reset(0);
        lat_fix = 0; hold_req = 1; pend = 3'b011;
        grant_log.delete();
        for (int n = 0; n < 200 && grant_log.size() < 4; n++) step();
        chk("rr_grant_count", grant_log.size() >= 4, 1'b1);
        if (grant_log.size() >= 4) begin
            chk("rr_grant0", grant_log[0], 0);
            chk("rr_grant1", grant_log[1], 1);
            chk("rr_grant2", grant_log[2], 0);
            chk("rr_grant3", grant_log[3], 1);
        end
        pend = '0; hold_req = 0;
        repeat (30) step();

        // backpressure in RESP, with spurious done pulses and a waiting request
        spur_en = 1; lat_fix = 5; rdy_val = 0;
        p_data[0] = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
        p_mode[0] = MODE_DEC;
        pend = 3'b001;
        clear_marks();
        run_until_rsp(40, "bp_rsp_seen");
        pend[1] = 1'b1;
        p_data[1] = rand128();
        for (int n = 0; n < 5; n++) begin
            step();
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 128'hf0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_req_ready", req_ready, '0);
        end
        rdy_val = 1;
        repeat (30) step();

        // spurious done while idle
        pend = '0;
        for (int n = 0; n < 12; n++) begin
            step();
            chk("spur_idle_busy", busy, 1'b0);
            chk("spur_idle_data", rsp_data, m_res);
        end
        spur_en = 0;

        // reset three cycles after core_start
        lat_fix = 30;
        p_data[0] = rand128();
        pend = 3'b001;
        clear_marks();
        for (int n = 0; n < 20 && first_start < 0; n++) step();
        chk("mid_start_seen", first_start >= 0, 1'b1);
        repeat (3) step();
        chk("mid_busy_before_reset", busy, 1'b1);
        do_reset(1);
        lat_fix = 0;
        pend = 3'b011;
        grant_log.delete();
        for (int n = 0; n < 10 && grant_log.size() == 0; n++) step();
        chk("mid_first_grant_seen", grant_log.size() > 0, 1'b1);
        if (grant_log.size() > 0) chk("mid_first_grant", grant_log[0], 0);
        pend = '0;
        repeat (30) step();

        // randomized traffic
        rnd_req = 1; rnd_rdy = 1; spur_en = 1; lat_fix = 0;
        repeat (3000) step();
        rnd_req = 0; rnd_rdy = 0; rdy_val = 1; spur_en = 0; pend = '0;
        repeat (40) step();

`ifdef AES_SCHED_TIMEOUT_EN
        // watchdog: core never answers
        do_reset(0);
        core_mute = 1;
        p_data[0] = rand128();
        pend = 3'b001;
        clear_marks();
        run_until_rsp(120, "wd_rsp_seen");
        chk("wd_rsp_cycle", first_rsp - acc_cyc, 66);
        chk("wd_rsp_err", first_rsp_err, 1'b1);
        chk("wd_rsp_data", first_rsp_data, '0);
        core_mute = 0;
        repeat (5) step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_core_scheduler.md
# aes_core_scheduler

Shares one AES round core (encrypt/decrypt sequencer plus datapath) between `NUM_REQ` requesters. Each requester offers one 128-bit block and a mode over a valid/ready handshake. The scheduler arbitrates round-robin, launches the core, waits for its `done`, and returns the result with the requester's ID over a valid/ready response port. Exactly one job is in flight at a time. The block sits between the bus-side request queues and the core's `start`/`done` interface.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response ID.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in BUSY; used only with the macro.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester job valid.
- `req_ready` out NUM_REQ: per-requester accept; one-hot or zero.
- `req_mode` in NUM_REQ: per-requester mode; 0 = encrypt, 1 = decrypt.
- `req_data` in NUM_REQ*128: packed input blocks; requester i occupies bits [i*128 +: 128].
- `core_start` out 1: one-cycle launch pulse to the core.
- `core_mode` out 1: mode of the job in flight; held stable from ISSUE through BUSY.
- `core_data_in` out 128: block of the job in flight; held stable from ISSUE through BUSY.
- `core_done` in 1: one-cycle completion pulse from the core.
- `core_data_out` in 128: core result; valid in the `core_done` cycle.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_data` out 128: result block.
- `rsp_id` out ID_W: index of the requester that owns the response.
- `rsp_err` out 1: job aborted by the watchdog.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, ISSUE, BUSY and RESP.
- **IDLE:** the arbiter selects the first asserted `req_valid` at or after index `ptr+1`, searching with wrap-around.
  - `req_ready` is high only for that winner, and combinationally only in IDLE.
  - On handshake: capture data, mode and ID into the job registers, set `ptr` = winner, go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE:** `core_start`=1 for exactly one cycle, then go to BUSY.
- **BUSY:** wait for `core_done`.
  - On `core_done`, capture `core_data_out` into `rsp_data`, set `rsp_err`=0, go to RESP.
- **RESP:** `rsp_valid`=1; `rsp_data`, `rsp_id` and `rsp_err` are held stable until `rsp_ready`.
  - On handshake, go to IDLE.
- **Round-robin pointer:**
  - `ptr` resets to NUM_REQ-1, so requester 0 wins first after reset.
  - `ptr` updates only on an accepted request.
- **Boundary conditions:**
  - `core_done` in IDLE, ISSUE or RESP is ignored, with no state or data change.
  - A `req_valid` that drops before its handshake is not a protocol error; arbitration simply re-evaluates the next cycle.
  - Requests arriving during ISSUE, BUSY or RESP see `req_ready`=0 and must hold.
  - Reset mid-job drops the in-flight job with no response. The core shares `reset_n` and is reset with it.
- **Reset values:** `req_ready`=0, `core_start`=0, `core_mode`=0, `core_data_in`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_err`=0, `busy`=0, state IDLE.

## Timing
- Request handshake in cycle 0.
- `core_start` in cycle 1.
- Core latency is L cycles: `core_done` arrives in cycle 1+L.
- `rsp_valid` rises in cycle 2+L.
- The earliest next request handshake is the cycle after the response handshake (IDLE is re-entered).
- Sustained throughput is one job per L+3 cycles when `rsp_ready` is held at 1.

## Configuration
- Macro: `AES_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches `TIMEOUT_CYCLES` without `core_done`, go to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `core_done` in the same cycle the limit is hit takes precedence and completes normally.
  - A late `core_done` after the abort is ignored under the IDLE/RESP rule.
- **Undefined:** no counter is built, `rsp_err` is tied to 0, and BUSY waits indefinitely.

## Structure
- Package `aes_sched_pkg` holds:
  - `sched_state_e` {S_IDLE, S_ISSUE, S_BUSY, S_RESP};
  - `AES_BLOCK_W`=128;
  - `MODE_ENC`=1'b0 and `MODE_DEC`=1'b1.
- Sub-module `rr_arbiter` (NUM_REQ): combinational masked priority pick from `req_valid` and `ptr`. It outputs a one-hot grant and an encoded index. `ptr` stays in the parent.

## Test plan
- **Single encrypt:** requester 0 sends `00112233445566778899aabbccddeeff` with mode 0; the core model has L=11.
  - Expect `core_start` at cycle 1, `rsp_valid` at cycle 13, `rsp_id`=0, and `rsp_data` equal to the model output.
- **Round-robin:** both requesters hold `req_valid` continuously.
  - Grants must alternate 0,1,0,1 over 4 jobs.
  - The first grant after reset goes to 0.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - `rsp_data` and `rsp_id` stay stable, and `req_ready` stays 0 throughout.
- **Spurious done:** pulse `core_done` in IDLE and in RESP.
  - No state change and no data change.
- **Reset mid-BUSY:** assert `reset_n`=0 three cycles after `core_start`.
  - All outputs go to their reset values immediately, and the next job is arbitrated with requester 0 first.
- **Watchdog (macro defined, TIMEOUT_CYCLES=64):** the core model never asserts done.
  - `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 appears 64 BUSY cycles after entry.
